// File: rtl/range_om_pkg.sv
// Shared types and helpers for the committed-store range capture block.
package range_om_pkg;

  typedef logic [31:0] addr_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } st_size_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic addr_t step_of(input st_size_e s);
    case (s)
      BYTE:    step_of = 32'd1;
      HALF:    step_of = 32'd2;
      default: step_of = 32'd4;
    endcase
  endfunction

endpackage

// File: rtl/range_capture_om.sv
// Detects runs of contiguous same-size committed stores and emits {first,last} byte ranges.
// Optional descending-run (stack push) tracking: define RANGE_CAPTURE_DESCENDING_EN.
module range_capture_om
  import range_om_pkg::*;
#(
  parameter int TIMEOUT   = 64,
  parameter int MIN_BYTES = 24,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             st_valid_i,
  input  logic [31:0]      st_addr_i,
  input  logic [1:0]       st_size_i,
  output logic             en_write_o,
  output logic [31:0]      addr_first_o,
  output logic [31:0]      addr_last_o,
  output logic             run_active_o,
  output logic [CNT_W-1:0] runs_emitted_o
);

  localparam int IW = $clog2(TIMEOUT + 1);

  state_e        state;
  addr_t         first, last;
  st_size_e      size_q;
  logic [IW-1:0] idle_cnt;

  st_size_e    in_size;
  addr_t       in_step, step, span_last, span;
  logic        legal, asc_ok, cont, timeout_hit, close, emit;
  logic [32:0] up_sum;

`ifdef RANGE_CAPTURE_DESCENDING_EN
  logic        desc, multi, dsc_ok, going_down;
  logic [32:0] dn_sum;
`endif

  always_comb begin
    in_size   = st_size_e'(st_size_i);
    in_step   = step_of(in_size);
    legal     = st_valid_i && (st_size_i != 2'd3) && ((st_addr_i & (in_step - 32'd1)) == '0);
    step      = step_of(size_q);
    // Carry out of last+step means the next address wrapped: never a continuation.
    up_sum    = {1'b0, last} + {1'b0, step};
    asc_ok    = !up_sum[32] && (up_sum[31:0] == st_addr_i) && (in_size == size_q);
`ifdef RANGE_CAPTURE_DESCENDING_EN
    dn_sum     = {1'b0, first} - {1'b0, step};
    dsc_ok     = !dn_sum[32] && (dn_sum[31:0] == st_addr_i) && (in_size == size_q);
    // Second store of a run picks the direction; afterwards only that direction extends.
    cont       = multi ? (desc ? dsc_ok : asc_ok) : (asc_ok || dsc_ok);
    going_down = multi ? desc : dsc_ok;
`else
    cont      = asc_ok;
`endif
    span_last   = last + step - 32'd1;
    span        = span_last - first + 32'd1;
    timeout_hit = (idle_cnt == IW'(TIMEOUT - 1));
    close       = (state == RUN) && (legal ? !cont : timeout_hit);
    emit        = close && (span >= 32'(MIN_BYTES));
  end

  assign run_active_o = (state == RUN);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state          <= IDLE;
      first          <= '0;
      last           <= '0;
      size_q         <= BYTE;
      idle_cnt       <= '0;
      en_write_o     <= 1'b0;
      addr_first_o   <= '0;
      addr_last_o    <= '0;
      runs_emitted_o <= '0;
`ifdef RANGE_CAPTURE_DESCENDING_EN
      desc           <= 1'b0;
      multi          <= 1'b0;
`endif
    end else begin
      en_write_o <= 1'b0;
      if (flush_i) begin
        state    <= IDLE;
        idle_cnt <= '0;
      end else begin
        if (emit) begin
          en_write_o   <= 1'b1;
          addr_first_o <= first;
          addr_last_o  <= span_last;
          if (runs_emitted_o != '1) runs_emitted_o <= runs_emitted_o + CNT_W'(1);
        end
        if (legal) begin
          idle_cnt <= '0;
          if (state == RUN && cont) begin
`ifdef RANGE_CAPTURE_DESCENDING_EN
            if (!multi) desc <= dsc_ok;
            multi <= 1'b1;
            if (going_down) first <= st_addr_i;
            else            last  <= st_addr_i;
`else
            last <= st_addr_i;
`endif
          end else begin
            state  <= RUN;
            first  <= st_addr_i;
            last   <= st_addr_i;
            size_q <= in_size;
`ifdef RANGE_CAPTURE_DESCENDING_EN
            desc   <= 1'b0;
            multi  <= 1'b0;
`endif
          end
        end else if (state == RUN) begin
          if (timeout_hit) begin
            state    <= IDLE;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
      end
    end
  end

endmodule

// File: doc/range_capture_om.md
Name: range_capture_om

Overview:
- Watches the committed-store stream from the core's commit stage and detects runs of contiguous, same-size stores (buffer/array fills).
- When a run closes, emits one write of {first byte address, last byte address} into the downstream object-range circular buffer.
- The downstream buffer later answers "is this address inside a known object".

Parameters:
- TIMEOUT, 64: idle cycles in a run without an accepted store before the run closes.
- MIN_BYTES, 24: minimum run span in bytes (last - first + 1) required to emit.
- CNT_W, 16: width of the emitted-run counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- flush_i  in  1  abandon current run, no emission
- st_valid_i  in  1  committed store this cycle
- st_addr_i  in  32  store byte address
- st_size_i  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- en_write_o  out  1  one-cycle write strobe to the range buffer
- addr_first_o  out  32  lowest byte address of the closed run
- addr_last_o  out  32  highest byte address of the closed run
- run_active_o  out  1  FSM in RUN
- runs_emitted_o  out  CNT_W  saturating count of emitted runs

Behaviour:
- Reset: all outputs are 0, FSM is IDLE, internal registers are 0. Reset is synchronous, active-low, and takes priority over everything.
- Step is 1 << size. A store is legal when st_size_i != 3 and the address is size-aligned. Illegal stores are ignored entirely.
- FSM IDLE:
  - A legal store sets first = addr, last = addr, size is latched, idle counter = 0, and the FSM goes to RUN.
- FSM RUN, legal store:
  - Same size and addr == last + step with no 32-bit carry: last = addr, idle counter = 0.
  - Any other legal store breaks the run: the current run closes, and the breaking store starts a new run in the same cycle (first = last = addr). FSM stays in RUN.
- FSM RUN, no legal store:
  - The idle counter increments.
  - When the counter would reach TIMEOUT, the run closes and the FSM goes to IDLE.
  - Net effect: closure is registered TIMEOUT cycles after the last accepted store.
- Close:
  - span_last = last + step - 1, computed in 32 bits. The carry cannot occur because runs never wrap.
  - If span_last - first + 1 >= MIN_BYTES: on the next edge en_write_o = 1, addr_first_o = first, addr_last_o = span_last, and runs_emitted_o increments, saturating at all-ones.
  - Otherwise there is no strobe and the outputs hold.
- Outputs are registered. en_write_o is high for exactly one cycle per emission. addr_first_o and addr_last_o hold their value until the next emission.
- Wrap-around: a store at 0x0 after a run ending at 0xFFFFFFFC is a break, never a continuation.
- flush_i:
  - Highest priority after reset. The FSM goes to IDLE and the run is discarded with no emission.
  - A same-cycle store is ignored, and a same-cycle closure is suppressed (en_write_o = 0 next cycle).
  - runs_emitted_o is unchanged.
- Back-to-back breaks each cycle: one emission per cycle is allowed. There is no stall and no backpressure; the downstream buffer always accepts.

Optional Feature:
- Macro: RANGE_CAPTURE_DESCENDING_EN.
- Defined:
  - A 1-bit direction flag is set by the second store of a run. addr == first - step means descending; this is how stack pushes appear.
  - A descending run continues while addr == first - step, with no borrow below 0x0; each such store sets first = addr.
  - Emitted first/last are always lowest/highest byte addresses.
- Undefined: only ascending runs exist, a descending store is a break, and no direction logic is synthesised.

Decomposition:
- Package range_om_pkg holds:
  - addr_t (logic[31:0])
  - st_size_e (BYTE, HALF, WORD)
  - state_e (IDLE, RUN)
  - function step_of(st_size_e) returning addr_t
- No sub-module. The idle timer and saturating counter stay inline.

Test Plan:
- Word stores 0x1000..0x101C (8 consecutive cycles), then a word store at 0x2000 -> the cycle after the 0x2000 store has en_write_o = 1, first = 0x1000, last = 0x101F, runs_emitted_o = 1, and run_active_o stays 1.
- Word stores 0x3000, 0x3004, 0x3008, then idle -> span 12 < 24: no strobe ever, run_active_o = 0 exactly TIMEOUT cycles after the 0x3008 store.
- 24 byte stores 0x4000..0x4017, then idle -> strobe TIMEOUT cycles after the last store, first = 0x4000, last = 0x4017.
- Word stores 0xFFFFFFE0..0xFFFFFFFC, then a word store at 0x0 -> strobe with first = 0xFFFFFFE0, last = 0xFFFFFFFF, and a new run starts at 0x0.
- 10 word stores from 0x5000, then flush_i and a store at 0x5028 in the same cycle -> no strobe, IDLE, counter unchanged. Next: 10 word stores, then rst_ni = 0 for one cycle -> all outputs 0 and no strobe afterwards.
- With RANGE_CAPTURE_DESCENDING_EN: word stores 0x8FFC, 0x8FF8, ..., 0x8FE0 (8 stores), then a store at 0x9100 -> strobe with first = 0x8FE0, last = 0x8FFF.
